// File: rtl/psk_symbol_scheduler.sv
// psk_symbol_scheduler
//   Transmit-side frame sequencer for the PSK modulator. Emits one symbol every DIV
//   clocks: PRE_LEN preamble symbols (00,11,00,...), then the payload bytes LSB first
//   (QPSK: 2 bits/symbol, BPSK: 1 bit duplicated onto both symbol bits), then
//   GUARD_LEN zero symbols. The BPSK/QPSK mode is latched at start for the whole frame.
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   start      frame request, sampled only while idle
//   is_bpsk    mode request (1=BPSK, 0=QPSK), sampled with start
//   frame_len  payload length in bytes, sampled with start
//   s_data     payload byte
//   s_valid    s_data valid
//   s_ready    byte accepted when s_valid & s_ready
//   sym_valid  one-cycle strobe per emitted symbol
//   sym_bits   symbol bits, held between strobes
//   bypass     latched frame mode (1=BPSK)
//   busy       high whenever the sequencer is not idle
//   underrun   sticky: frame aborted because no byte was available in time
module psk_symbol_scheduler #(
    parameter int unsigned DIV       = 8,
    parameter int unsigned PRE_LEN   = 16,
    parameter int unsigned GUARD_LEN = 4,
    parameter int unsigned LEN_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 is_bpsk,
    input  logic [LEN_WIDTH-1:0] frame_len,
    input  logic [7:0]           s_data,
    input  logic                 s_valid,
    output logic                 s_ready,
    output logic                 sym_valid,
    output logic [1:0]           sym_bits,
    output logic                 bypass,
    output logic                 busy,
    output logic                 underrun
);

    localparam int unsigned MaxPg  = (PRE_LEN > GUARD_LEN) ? PRE_LEN : GUARD_LEN;
    localparam int unsigned MaxLen = (MaxPg > 8) ? MaxPg : 8;
    localparam int unsigned SymW   = $clog2(MaxLen) + 1;
    localparam int unsigned DivW   = $clog2(DIV);

    typedef enum logic [1:0] {StIdle, StPre, StPay, StGuard} state_e;

    state_e               state;
    logic [DivW-1:0]      div_cnt;
    logic [SymW-1:0]      sym_cnt;
    logic [2:0]           bit_cnt;
    logic [LEN_WIDTH-1:0] len_cnt;
    logic [7:0]           shreg;
    logic                 need_byte;

    logic strobe;
    logic last_sym;
    logic handshake;

    assign strobe    = (state != StIdle) && (div_cnt == DivW'(DIV - 1));
    assign last_sym  = bypass ? (bit_cnt == 3'd7) : (bit_cnt == 3'd3);
    assign s_ready   = (state == StPay) && need_byte;
    assign handshake = s_valid && s_ready;
    assign busy      = (state != StIdle);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= StIdle;
            div_cnt   <= '0;
            sym_cnt   <= '0;
            bit_cnt   <= '0;
            len_cnt   <= '0;
            shreg     <= '0;
            need_byte <= 1'b0;
            sym_valid <= 1'b0;
            sym_bits  <= 2'b00;
            bypass    <= 1'b0;
            underrun  <= 1'b0;
        end else begin
            sym_valid <= 1'b0;

            if (state == StIdle) begin
                div_cnt <= '0;
            end else begin
                div_cnt <= strobe ? '0 : div_cnt + 1'b1;
            end

            // need_byte is only ever set while len_cnt != 0, so len_cnt cannot wrap.
            if (handshake) begin
                shreg     <= s_data;
                need_byte <= 1'b0;
                len_cnt   <= len_cnt - 1'b1;
            end

            case (state)
                StIdle: begin
                    sym_bits <= 2'b00;
                    if (start) begin
                        bypass   <= is_bpsk;
                        len_cnt  <= frame_len;
                        underrun <= 1'b0;
                        sym_cnt  <= '0;
                        bit_cnt  <= '0;
                        state    <= StPre;
                    end
                end
                StPre: begin
                    if (strobe) begin
                        sym_valid <= 1'b1;
                        sym_bits  <= sym_cnt[0] ? 2'b11 : 2'b00;
                        if (sym_cnt == SymW'(PRE_LEN - 1)) begin
                            sym_cnt <= '0;
                            if (len_cnt == '0) begin
                                state <= StGuard;
                            end else begin
                                state     <= StPay;
                                need_byte <= 1'b1;
                                bit_cnt   <= '0;
                            end
                        end else begin
                            sym_cnt <= sym_cnt + 1'b1;
                        end
                    end
                end
                StPay: begin
                    if (strobe) begin
                        if (need_byte) begin
                            // No byte arrived in a whole symbol period: abort to guard.
                            underrun  <= 1'b1;
                            need_byte <= 1'b0;
                            sym_cnt   <= '0;
                            state     <= StGuard;
                        end else begin
                            sym_valid <= 1'b1;
                            if (bypass) begin
                                sym_bits <= {shreg[0], shreg[0]};
                                shreg    <= {1'b0, shreg[7:1]};
                            end else begin
                                sym_bits <= shreg[1:0];
                                shreg    <= {2'b00, shreg[7:2]};
                            end
                            if (last_sym) begin
                                bit_cnt <= '0;
                                // len_cnt already counts this byte, so zero means it was the last one.
                                if (len_cnt == '0) begin
                                    sym_cnt <= '0;
                                    state   <= StGuard;
                                end else begin
                                    need_byte <= 1'b1;
                                end
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                            end
                        end
                    end
                end
                StGuard: begin
                    if (strobe) begin
                        sym_valid <= 1'b1;
                        sym_bits  <= 2'b00;
                        if (sym_cnt == SymW'(GUARD_LEN - 1)) begin
                            sym_cnt <= '0;
                            state   <= StIdle;
                        end else begin
                            sym_cnt <= sym_cnt + 1'b1;
                        end
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_psk_symbol_scheduler.sv
module tb_psk_symbol_scheduler;

    localparam int DIV = 8;
    localparam int PRE = 16;
    localparam int GRD = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       is_bpsk = 1'b0;
    logic [7:0] frame_len = 8'd0;
    logic [7:0] s_data = 8'd0;
    logic       s_valid = 1'b0;
    logic       s_ready;
    logic       sym_valid;
    logic [1:0] sym_bits;
    logic       bypass;
    logic       busy;
    logic       underrun;

    psk_symbol_scheduler #(
        .DIV       (DIV),
        .PRE_LEN   (PRE),
        .GUARD_LEN (GRD),
        .LEN_WIDTH (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .is_bpsk   (is_bpsk),
        .frame_len (frame_len),
        .s_data    (s_data),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .sym_valid (sym_valid),
        .sym_bits  (sym_bits),
        .bypass    (bypass),
        .busy      (busy),
        .underrun  (underrun)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad = 0;

    logic [1:0] syms[$];
    logic [7:0] src[4];
    int         busy_cycles;
    int         first_off;
    int         spacing_bad;
    int         bypass_bad;
    int         sready_seen;
    logic       ur_k1;
    logic [1:0] bits_before_rst;

    // Hand-computed payload symbol vectors.
    int p_qpsk_b4_1e[8] = '{0, 1, 3, 2, 2, 3, 1, 0};
    int p_bpsk_05[8]    = '{3, 0, 3, 0, 0, 0, 0, 0};
    int p_qpsk_1e[8]    = '{2, 3, 1, 0, 0, 0, 0, 0};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Starts one frame and runs it to IDLE (or to the reset point when rst_at != 0),
    // feeding nbytes from src[] and recording every symbol strobe.
    task automatic run_frame(input logic bpsk, input int len, input int nbytes,
                             input int poke_at, input int rst_at);
        int   bi;
        int   last;
        logic hs_armed;
        bit   done;
        syms.delete();
        busy_cycles = 0;
        first_off   = -1;
        spacing_bad = 0;
        bypass_bad  = 0;
        sready_seen = 0;
        bi       = 0;
        last     = 0;
        hs_armed = 1'b0;
        done     = 1'b0;
        @(negedge clk);
        is_bpsk   = bpsk;
        frame_len = len[7:0];
        s_valid   = 1'b0;
        start     = 1'b1;
        last      = cyc;
        for (int k = 1; k <= 4000 && !done; k++) begin
            @(negedge clk);
            if (k == 1) begin
                start = 1'b0;
                ur_k1 = underrun;
            end
            if (rst_at != 0 && k == rst_at) begin
                bits_before_rst = sym_bits;
                #2 rst = 1'b1;
                #1;
                check("rst_sym_valid", 32'(sym_valid), 0);
                check("rst_sym_bits", 32'(sym_bits), 0);
                check("rst_bypass", 32'(bypass), 0);
                check("rst_busy", 32'(busy), 0);
                check("rst_underrun", 32'(underrun), 0);
                check("rst_s_ready", 32'(s_ready), 0);
                s_valid = 1'b0;
                @(negedge clk);
                rst  = 1'b0;
                done = 1'b1;
            end else begin
                if (sym_valid) begin
                    syms.push_back(sym_bits);
                    if (first_off < 0) first_off = cyc - last;
                    else if (cyc - last != DIV) spacing_bad++;
                    last = cyc;
                end
                if (!busy) begin
                    done = 1'b1;
                end else begin
                    busy_cycles++;
                    if (bypass !== bpsk) bypass_bad++;
                    if (s_ready) sready_seen++;
                    if (hs_armed) bi++;
                    if (bi < nbytes) begin
                        s_valid = 1'b1;
                        s_data  = src[bi];
                    end else begin
                        s_valid = 1'b0;
                        s_data  = 8'h00;
                    end
                    hs_armed = s_valid && s_ready;
                    if (poke_at != 0 && k == poke_at) begin
                        is_bpsk = ~bpsk;
                        start   = 1'b1;
                    end else if (poke_at != 0 && k == poke_at + 1) begin
                        start = 1'b0;
                    end
                end
            end
        end
        if (!done) check("timeout", 0, 1);
        s_valid = 1'b0;
        start   = 1'b0;
    endtask

    task automatic check_frame(input string tag, input int pay[8], input int npay);
        int n;
        logic [31:0] exp;
        logic [31:0] got;
        n = PRE + npay + GRD;
        check({tag, "_nsym"}, syms.size(), n);
        for (int i = 0; i < n; i++) begin
            if (i < PRE) exp = (i % 2 == 1) ? 3 : 0;
            else if (i < PRE + npay) exp = pay[i - PRE];
            else exp = 0;
            got = (i < syms.size()) ? 32'(syms[i]) : 32'hFFFF_FFFF;
            check($sformatf("%s_sym%0d", tag, i), got, exp);
        end
    endtask

    initial begin
        // Reset state
        #12;
        check("reset_busy", 32'(busy), 0);
        check("reset_sym_valid", 32'(sym_valid), 0);
        check("reset_sym_bits", 32'(sym_bits), 0);
        check("reset_s_ready", 32'(s_ready), 0);
        check("reset_underrun", 32'(underrun), 0);
        check("reset_bypass", 32'(bypass), 0);
        @(negedge clk);
        rst = 1'b0;

        // 1: QPSK, two bytes, source always valid
        src[0] = 8'hB4; src[1] = 8'h1E;
        run_frame(1'b0, 2, 2, 0, 0);
        check_frame("t1", p_qpsk_b4_1e, 8);
        check("t1_first_off", first_off, DIV + 1);
        check("t1_spacing", spacing_bad, 0);
        check("t1_busy_cycles", busy_cycles, (PRE + 8 + GRD) * DIV);
        check("t1_underrun", 32'(underrun), 0);
        check("t1_bypass_hold", bypass_bad, 0);

        // 2: BPSK, one byte
        src[0] = 8'h05;
        run_frame(1'b1, 1, 1, 0, 0);
        check_frame("t2", p_bpsk_05, 8);
        check("t2_bypass_hold", bypass_bad, 0);
        check("t2_busy_cycles", busy_cycles, (PRE + 8 + GRD) * DIV);
        check("t2_spacing", spacing_bad, 0);

        // 3: three bytes requested, only two supplied
        src[0] = 8'hB4; src[1] = 8'h1E;
        run_frame(1'b0, 3, 2, 0, 0);
        check_frame("t3", p_qpsk_b4_1e, 8);
        check("t3_underrun", 32'(underrun), 1);
        check("t3_busy_cycles", busy_cycles, (PRE + 8 + 1 + GRD) * DIV);

        // 4: mode toggle and start pulse mid-frame are ignored
        src[0] = 8'h1E;
        run_frame(1'b0, 1, 1, 100, 0);
        check("t4_underrun_cleared", 32'(ur_k1), 0);
        check_frame("t4a", p_qpsk_1e, 4);
        check("t4a_bypass_hold", bypass_bad, 0);
        check("t4a_busy_cycles", busy_cycles, (PRE + 4 + GRD) * DIV);
        repeat (3) @(negedge clk);
        check("t4_no_new_frame", 32'(busy), 0);
        src[0] = 8'h05;
        run_frame(1'b1, 1, 1, 0, 0);
        check_frame("t4b", p_bpsk_05, 8);
        check("t4b_bypass_hold", bypass_bad, 0);

        // 5: reset in PAY mid-byte, then a clean repeat of test 1
        src[0] = 8'hB4; src[1] = 8'h1E;
        run_frame(1'b0, 2, 2, 0, 150);
        check("t5_bits_before_rst", 32'(bits_before_rst), 1);
        run_frame(1'b0, 2, 2, 0, 0);
        check_frame("t5", p_qpsk_b4_1e, 8);
        check("t5_first_off", first_off, DIV + 1);
        check("t5_spacing", spacing_bad, 0);
        check("t5_busy_cycles", busy_cycles, (PRE + 8 + GRD) * DIV);

        // 6: empty payload goes straight from preamble to guard
        run_frame(1'b0, 0, 0, 0, 0);
        check_frame("t6", p_qpsk_1e, 0);
        check("t6_s_ready_never", sready_seen, 0);
        check("t6_busy_cycles", busy_cycles, (PRE + GRD) * DIV);
        check("t6_underrun", 32'(underrun), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
